// File: rtl/serial_adder_ctrl.sv
// ============================================================================
// serial_adder_ctrl: bit-serial N-bit adder. One full_adder cell is reused
// LSB first over WIDTH cycles, and the design pulses done when the result is ready.
// Revision: 1.0
// ============================================================================
`default_nettype none

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);

  localparam int              IDXW     = $clog2(WIDTH);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry_reg;
  logic [IDXW-1:0]  idx;
  logic             fa_s;
  logic             fa_cout;

  full_adder fa (
    .A    (a_reg[idx]),
    .B    (b_reg[idx]),
    .Cin  (carry_reg),
    .S    (fa_s),
    .Cout (fa_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      S         <= '0;
      Cout      <= 1'b0;
      idx       <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_reg     <= A;
            b_reg     <= B;
            carry_reg <= Cin;
            idx       <= '0;
            busy      <= 1'b1;
            state     <= ADD;
          end
        end
        ADD: begin
          S[idx]    <= fa_s;
          carry_reg <= fa_cout;
          // Exit is taken at the last bit so idx never needs to wrap.
          if (idx == LAST_IDX) begin
            Cout  <= fa_cout;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// Single-bit full adder cell time-shared by the controller.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);

  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: vector table at WIDTH=8, directed
// corner sequences, and an exhaustive sweep at WIDTH=4.
`default_nettype none

module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] A, B;
  logic       Cin;
  logic       busy, done;
  logic [7:0] S;
  logic       Cout;

  logic       start4;
  logic [3:0] A4, B4;
  logic       Cin4;
  logic       busy4, done4;
  logic [3:0] S4;
  logic       Cout4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Cin(Cin),
    .busy(busy), .done(done), .S(S), .Cout(Cout)
  );

  serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .A(A4), .B(B4), .Cin(Cin4),
    .busy(busy4), .done(done4), .S(S4), .Cout(Cout4)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       cout;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Accepts one operation on the WIDTH=8 instance and waits for done.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                      output int lat, output int bcnt, output int overlap);
    A = a; B = b; Cin = cin; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0; bcnt = 0; overlap = 0;
    while (lat < 30) begin
      lat++;
      if (busy) bcnt++;
      if (busy && done) overlap++;
      if (done) break;
      tick();
    end
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic cin,
                      output int lat);
    A4 = a; B4 = b; Cin4 = cin; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    lat = 0;
    while (lat < 20) begin
      lat++;
      if (done4) break;
      tick();
    end
  endtask

  initial begin
    int lat, bcnt, ovl, dcnt, last, ndone, hold;

    vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    vecs[4] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[7] = '{8'h3C, 8'hC3, 1'b0, 8'hFF, 1'b0};
    vecs[8] = '{8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1};

    rst = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
    start4 = 1'b0; A4 = '0; B4 = '0; Cin4 = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    chk("reset S", 32'(S), 0);
    chk("reset Cout", 32'(Cout), 0);

    for (int i = 0; i < 9; i++) begin
      run8(vecs[i].a, vecs[i].b, vecs[i].cin, lat, bcnt, ovl);
      chk($sformatf("vec%0d latency", i), 32'(lat), 9);
      chk($sformatf("vec%0d busy cycles", i), 32'(bcnt), 8);
      chk($sformatf("vec%0d busy&done", i), 32'(ovl), 0);
      chk($sformatf("vec%0d S", i), 32'(S), 32'(vecs[i].s));
      chk($sformatf("vec%0d Cout", i), 32'(Cout), 32'(vecs[i].cout));
      tick();
      chk($sformatf("vec%0d done width", i), 32'(done), 0);
    end

    // start during busy is ignored; operands change after accept
    A = 8'h12; B = 8'h34; Cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    A = 8'hFF; B = 8'hFF; start = 1'b1;
    tick(); tick();
    start = 1'b0;
    dcnt = 0;
    for (int t = 0; t < 25; t++) begin
      if (done) begin
        dcnt++;
        chk("ignore-start S", 32'(S), 32'h46);
        chk("ignore-start Cout", 32'(Cout), 0);
      end
      tick();
    end
    chk("ignore-start done count", 32'(dcnt), 1);
    chk("ignore-start idle", 32'(busy), 0);

    // reset in the 4th ADD cycle aborts the operation
    A = 8'hFF; B = 8'hFF; Cin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("abort pre busy", 32'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort busy", 32'(busy), 0);
    chk("abort done", 32'(done), 0);
    chk("abort S", 32'(S), 0);
    chk("abort Cout", 32'(Cout), 0);
    dcnt = 0;
    for (int t = 0; t < 15; t++) begin
      tick();
      if (done || busy) dcnt++;
    end
    chk("abort no activity", 32'(dcnt), 0);

    // start and rst together: reset wins
    A = 8'h01; B = 8'h01; start = 1'b1; rst = 1'b1;
    tick();
    start = 1'b0; rst = 1'b0;
    tick();
    chk("rst+start busy", 32'(busy), 0);

    // start held high: one accept every 10 cycles, result stable meanwhile
    A = 8'h5A; B = 8'h33; Cin = 1'b0; start = 1'b1;
    last = -1; ndone = 0; hold = 0;
    for (int t = 0; t < 50 && ndone < 3; t++) begin
      tick();
      if (hold > 0) begin
        chk("held S stable", 32'(S), 32'h8D);
        hold--;
      end
      if (done) begin
        chk("held S", 32'(S), 32'h8D);
        chk("held Cout", 32'(Cout), 0);
        if (last >= 0) chk("held interval", 32'(t - last), 10);
        last = t;
        ndone++;
        hold = 2;
      end
    end
    start = 1'b0;
    chk("held done count", 32'(ndone), 3);
    for (int t = 0; t < 20 && (busy || done); t++) tick();
    tick();

    // exhaustive WIDTH=4
    for (int v = 0; v < 512; v++) begin
      logic [3:0] a, b;
      logic       c;
      logic [4:0] exp;
      a = 4'(v >> 5); b = 4'(v >> 1); c = v[0];
      exp = 5'(a) + 5'(b) + 5'(c);
      run4(a, b, c, lat);
      chk($sformatf("w4 %h+%h+%b", a, b, c), {22'd0, lat == 5, Cout4, S4}, {22'd0, 1'b1, exp});
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
